// File: rtl/mfp_ahb_eic_pkg.sv
// Shared constants, bus phase record and register-map helpers for the M14K EIC.
// The SRS registers are only decoded when MFP_EIC_SHADOW_EN is defined.
package mfp_ahb_eic_pkg;

    localparam int unsigned MFP_N_IRQ  = 8;
    localparam int unsigned MFP_PRIO_W = 4;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Word indices, i.e. HADDR[5:2]
    localparam logic [3:0] REG_PEND   = 4'h0;
    localparam logic [3:0] REG_MASK   = 4'h1;
    localparam logic [3:0] REG_EDGE   = 4'h2;
    localparam logic [3:0] REG_CLEAR  = 4'h3;
    localparam logic [3:0] REG_PRIO0  = 4'h4;
    localparam logic [3:0] REG_ACTIVE = 4'h8;
    localparam logic [3:0] REG_SRS0   = 4'h9;

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [2:0] size;
        logic [3:0] addr;
    } ahb_aphase_t;

    // Nibble-packed tables hold eight sources per word
    function automatic logic [3:0] nib_word(input logic [3:0] base, input int unsigned k);
        return base + 4'(k / 8);
    endfunction

endpackage

// File: rtl/mfp_eic_arbiter.sv
// Combinational highest-priority search; ties resolve to the lowest source index.
module mfp_eic_arbiter
    import mfp_ahb_eic_pkg::*;
#(
    parameter int unsigned N_IRQ  = MFP_N_IRQ,
    parameter int unsigned PRIO_W = MFP_PRIO_W
) (
    input  logic [N_IRQ-1:0]        eligible,
    input  logic [N_IRQ*PRIO_W-1:0] prio,
    output logic                    valid,
    output logic [5:0]              index,
    output logic [PRIO_W-1:0]       win_prio
);

    always_comb begin
        valid    = 1'b0;
        index    = '0;
        win_prio = '0;
        // Strict greater-than keeps the earlier (lower) index on equal priority
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            if (eligible[k] && (prio[k*PRIO_W +: PRIO_W] > win_prio)) begin
                valid    = 1'b1;
                index    = 6'(k);
                win_prio = prio[k*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/mfp_ahb_eic.sv
// AHB-Lite External Interrupt Controller presenting the winning request to the M14K.
// Define MFP_EIC_SHADOW_EN to add per-source shadow register set selection (SI_EISS).
module mfp_ahb_eic
    import mfp_ahb_eic_pkg::*;
#(
    parameter int unsigned N_IRQ  = MFP_N_IRQ,
    parameter int unsigned PRIO_W = MFP_PRIO_W
) (
    input  logic              HCLK,
    input  logic              SI_Reset,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADY,
    output logic              HRESP,
    input  logic [N_IRQ-1:0]  IRQ_In,
    input  logic              SI_IAck,
    input  logic [5:0]        SI_IVN,
    output logic [7:0]        SI_Int,
    output logic              SI_EICPresent,
    output logic [5:0]        SI_EICVector,
    output logic [3:0]        SI_EISS,
    output logic [16:0]       SI_Offset
);

    logic [N_IRQ-1:0]        sync1, sync2, sync3, rise, clr;
    logic [N_IRQ-1:0]        pend, mask, edge_mode, eligible;
    logic [PRIO_W-1:0]       prio [N_IRQ];
    logic [N_IRQ*PRIO_W-1:0] prio_flat;
    ahb_aphase_t             aph;
    logic                    wr_en;
    logic                    win_valid;
    logic [5:0]              win_idx;
    logic [PRIO_W-1:0]       win_prio;
    logic [5:0]              ipl_q, vec_q;
    logic [31:0]             rdata;
    logic                    unused_ok;

    assign wr_en = aph.valid && aph.write && (aph.size == HSIZE_WORD);
    assign rise  = sync2 & ~sync3;

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            aph <= '0;
        end else begin
            aph.valid <= HSEL & HTRANS[1];
            aph.write <= HWRITE;
            aph.size  <= HSIZE;
            aph.addr  <= HADDR[5:2];
        end
    end

    always_comb begin
        clr = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            clr[k] = (wr_en && (aph.addr == REG_CLEAR) && HWDATA[k]) ||
                     (SI_IAck && (SI_IVN == 6'(k)));
        end
    end

    // A rising edge beats a same-cycle clear so no edge request is ever lost
    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            pend  <= '0;
        end else begin
            sync1 <= IRQ_In;
            sync2 <= sync1;
            sync3 <= sync2;
            for (int unsigned k = 0; k < N_IRQ; k++) begin
                if (!edge_mode[k])
                    pend[k] <= sync2[k];
                else if (rise[k])
                    pend[k] <= 1'b1;
                else if (clr[k])
                    pend[k] <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            mask      <= '0;
            edge_mode <= '0;
            for (int unsigned k = 0; k < N_IRQ; k++) prio[k] <= '0;
        end else if (wr_en) begin
            if (aph.addr == REG_MASK) mask      <= HWDATA[N_IRQ-1:0];
            if (aph.addr == REG_EDGE) edge_mode <= HWDATA[N_IRQ-1:0];
            for (int unsigned k = 0; k < N_IRQ; k++) begin
                if (aph.addr == nib_word(REG_PRIO0, k))
                    prio[k] <= HWDATA[4*(k%8) +: PRIO_W];
            end
        end
    end

`ifdef MFP_EIC_SHADOW_EN
    logic [3:0] srs [N_IRQ];
    logic [3:0] win_srs;
    logic [3:0] eiss_q;

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            for (int unsigned k = 0; k < N_IRQ; k++) srs[k] <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < N_IRQ; k++) begin
                if (aph.addr == nib_word(REG_SRS0, k))
                    srs[k] <= HWDATA[4*(k%8) +: 4];
            end
        end
    end

    always_comb begin
        win_srs = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            if (win_idx == 6'(k)) win_srs = srs[k];
        end
    end

    always_ff @(posedge HCLK) begin
        if (SI_Reset) eiss_q <= '0;
        else          eiss_q <= win_valid ? win_srs : '0;
    end

    assign SI_EISS = eiss_q;
`else
    assign SI_EISS = '0;
`endif

    always_comb begin
        prio_flat = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            prio_flat[k*PRIO_W +: PRIO_W] = prio[k];
            eligible[k] = pend[k] && mask[k] && (prio[k] != '0);
        end
    end

    mfp_eic_arbiter #(
        .N_IRQ  (N_IRQ),
        .PRIO_W (PRIO_W)
    ) u_arbiter (
        .eligible (eligible),
        .prio     (prio_flat),
        .valid    (win_valid),
        .index    (win_idx),
        .win_prio (win_prio)
    );

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            ipl_q <= '0;
            vec_q <= '0;
        end else begin
            ipl_q <= win_valid ? 6'(win_prio) : '0;
            vec_q <= win_valid ? win_idx : '0;
        end
    end

    always_comb begin
        rdata = '0;
        if (aph.valid && !aph.write) begin
            case (aph.addr)
                REG_PEND:   rdata[N_IRQ-1:0] = pend;
                REG_MASK:   rdata[N_IRQ-1:0] = mask;
                REG_EDGE:   rdata[N_IRQ-1:0] = edge_mode;
                REG_ACTIVE: rdata = {18'd0, ipl_q, 2'd0, vec_q};
                default: begin
                    for (int unsigned k = 0; k < N_IRQ; k++) begin
                        if (aph.addr == nib_word(REG_PRIO0, k))
                            rdata[4*(k%8) +: PRIO_W] = prio[k];
`ifdef MFP_EIC_SHADOW_EN
                        if (aph.addr == nib_word(REG_SRS0, k))
                            rdata[4*(k%8) +: 4] = srs[k];
`endif
                    end
                end
            endcase
        end
    end

    assign HRDATA        = rdata;
    assign HREADY        = 1'b1;
    assign HRESP         = 1'b0;
    assign SI_Int        = {2'b00, ipl_q};
    assign SI_EICVector  = vec_q;
    assign SI_EICPresent = 1'b1;
    assign SI_Offset     = '0;
    assign unused_ok     = ^{HADDR[31:6], HADDR[1:0], HTRANS[0], HWDATA};

endmodule

// File: tb/tb_mfp_ahb_eic.sv
// Directed bench for mfp_ahb_eic with a cycle-level reference model of the EIC rules.
// Expectations follow MFP_EIC_SHADOW_EN when the macro is defined for the build.
module tb_mfp_ahb_eic;

    localparam int unsigned NI = 8;

    logic          HCLK = 1'b0;
    logic          SI_Reset, HSEL, HWRITE, SI_IAck;
    logic [31:0]   HADDR, HWDATA, HRDATA;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HREADY, HRESP;
    logic [NI-1:0] IRQ_In;
    logic [5:0]    SI_IVN;
    logic [7:0]    SI_Int;
    logic          SI_EICPresent;
    logic [5:0]    SI_EICVector;
    logic [3:0]    SI_EISS;
    logic [16:0]   SI_Offset;

    int n_checks = 0;
    int n_fail   = 0;

    mfp_ahb_eic #(.N_IRQ(NI), .PRIO_W(4)) dut (
        .HCLK          (HCLK),
        .SI_Reset      (SI_Reset),
        .HSEL          (HSEL),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HWRITE        (HWRITE),
        .HSIZE         (HSIZE),
        .HWDATA        (HWDATA),
        .HRDATA        (HRDATA),
        .HREADY        (HREADY),
        .HRESP         (HRESP),
        .IRQ_In        (IRQ_In),
        .SI_IAck       (SI_IAck),
        .SI_IVN        (SI_IVN),
        .SI_Int        (SI_Int),
        .SI_EICPresent (SI_EICPresent),
        .SI_EICVector  (SI_EICVector),
        .SI_EISS       (SI_EISS),
        .SI_Offset     (SI_Offset)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: irq sample history, register file and the pending data phase
    logic [NI-1:0] m_pend, m_mask, m_edge, x1, x2, x3;
    logic [3:0]    m_prio [NI];
    logic [3:0]    m_srs  [NI];
    logic [5:0]    m_ipl, m_vec;
    logic [3:0]    m_eiss;
    logic          ph_v, ph_w;
    logic [3:0]    ph_a;
    logic [2:0]    ph_s;
    bit            model_on = 0;

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            4'h0: v[NI-1:0] = m_pend;
            4'h1: v[NI-1:0] = m_mask;
            4'h2: v[NI-1:0] = m_edge;
            4'h4: for (int k = 0; k < NI; k++) v[4*k +: 4] = m_prio[k];
            4'h8: v = {18'd0, m_ipl, 2'd0, m_vec};
`ifdef MFP_EIC_SHADOW_EN
            4'h9: for (int k = 0; k < NI; k++) v[4*k +: 4] = m_srs[k];
`endif
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge HCLK) begin : model
        logic [NI-1:0] clr;
        int            best, bv;
        logic [3:0]    bs;
        logic          wr;
        if (SI_Reset) begin
            m_pend = '0; m_mask = '0; m_edge = '0;
            x1 = '0; x2 = '0; x3 = '0;
            for (int k = 0; k < NI; k++) begin m_prio[k] = '0; m_srs[k] = '0; end
            m_ipl = '0; m_vec = '0; m_eiss = '0;
            ph_v = 0; ph_w = 0; ph_a = '0; ph_s = '0;
            model_on = 1;
        end else begin
            // Outputs register the winner of the state visible before this edge
            best = 0; bv = 0; bs = '0;
            for (int k = 0; k < NI; k++) begin
                if (m_pend[k] && m_mask[k] && int'(m_prio[k]) > best) begin
                    best = int'(m_prio[k]); bv = k; bs = m_srs[k];
                end
            end
            m_ipl = 6'(best);
            m_vec = 6'(bv);
`ifdef MFP_EIC_SHADOW_EN
            m_eiss = bs;
`else
            m_eiss = '0;
`endif
            wr  = ph_v && ph_w && (ph_s == 3'b010);
            clr = (wr && ph_a == 4'h3) ? HWDATA[NI-1:0] : '0;
            if (SI_IAck && SI_IVN < 6'(NI)) clr[SI_IVN[2:0]] = 1'b1;
            // x2 = line sampled two edges ago, x3 = three edges ago
            for (int k = 0; k < NI; k++) begin
                if (!m_edge[k])             m_pend[k] = x2[k];
                else if (x2[k] && !x3[k])   m_pend[k] = 1'b1;
                else if (clr[k])            m_pend[k] = 1'b0;
            end
            if (wr) begin
                case (ph_a)
                    4'h1: m_mask = HWDATA[NI-1:0];
                    4'h2: m_edge = HWDATA[NI-1:0];
                    4'h4: for (int k = 0; k < NI; k++) m_prio[k] = HWDATA[4*k +: 4];
`ifdef MFP_EIC_SHADOW_EN
                    4'h9: for (int k = 0; k < NI; k++) m_srs[k] = HWDATA[4*k +: 4];
`endif
                    default: ;
                endcase
            end
            x3 = x2; x2 = x1; x1 = IRQ_In;
            ph_v = HSEL && HTRANS[1];
            ph_w = HWRITE;
            ph_a = HADDR[5:2];
            ph_s = HSIZE;
        end
    end

    always @(negedge HCLK) begin
        if (model_on) begin
            chk("si_int",  32'(SI_Int),       32'(m_ipl));
            chk("vector",  32'(SI_EICVector), 32'(m_vec));
            chk("eiss",    32'(SI_EISS),      32'(m_eiss));
            chk("hrdata",  HRDATA, (ph_v && !ph_w) ? model_read(ph_a) : 32'd0);
            chk("present", 32'(SI_EICPresent), 32'd1);
            chk("hready",  32'(HREADY),       32'd1);
            chk("hresp",   32'(HRESP),        32'd0);
            chk("offset",  32'(SI_Offset),    32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge HCLK);
            @(negedge HCLK);
        end
    endtask

    task automatic bus_addr(input logic w, input logic [31:0] a, input logic [2:0] sz);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a; HSIZE = sz;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz = 3'b010);
        bus_addr(1'b1, a, sz);
        tick(1);
        HWDATA = d;
        bus_idle();
        tick(1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_addr(1'b0, a, 3'b010);
        tick(1);
        d = HRDATA;
        bus_idle();
    endtask

    initial begin
        logic [31:0] d;
        SI_Reset = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
        HSIZE = 3'b010; HWDATA = '0; IRQ_In = '0; SI_IAck = 1'b0; SI_IVN = '0;
        @(negedge HCLK);
        tick(2);
        SI_Reset = 1'b0;

        // Reset state
        for (int i = 0; i < 16; i++) begin
            rd(32'(i * 4), d);
            chk($sformatf("reset_rd_%0d", i), d, 32'd0);
        end
        chk("reset_int", 32'(SI_Int), 32'd0);
        chk("reset_vec", 32'(SI_EICVector), 32'd0);
        chk("reset_present", 32'(SI_EICPresent), 32'd1);

        // Level sources 0 and 2
        wr(32'h04, 32'h05);
        wr(32'h08, 32'h00);
        wr(32'h10, 32'h0000_0703);
        IRQ_In[0] = 1'b1;
        tick(3);
        chk("lvl0_not_yet", 32'(SI_Int), 32'd0);
        tick(1);
        chk("lvl0_int", 32'(SI_Int), 32'd3);
        chk("lvl0_vec", 32'(SI_EICVector), 32'd0);
        IRQ_In[2] = 1'b1;
        tick(4);
        chk("lvl2_int", 32'(SI_Int), 32'd7);
        chk("lvl2_vec", 32'(SI_EICVector), 32'd2);
        IRQ_In = '0;
        tick(6);
        chk("lvl_idle", 32'(SI_Int), 32'd0);

        // Edge source 1, one-cycle pulse then acknowledge
        wr(32'h08, 32'h02);
        wr(32'h04, 32'h02);
        wr(32'h10, 32'h0000_0753);
        IRQ_In[1] = 1'b1;
        tick(1);
        IRQ_In[1] = 1'b0;
        tick(5);
        rd(32'h00, d);
        chk("edge_held", d, 32'h2);
        chk("edge_int", 32'(SI_Int), 32'd5);
        chk("edge_vec", 32'(SI_EICVector), 32'd1);
        SI_IAck = 1'b1; SI_IVN = 6'd1;
        tick(1);
        SI_IAck = 1'b0; SI_IVN = 6'd0;
        tick(1);
        chk("ack_int", 32'(SI_Int), 32'd0);
        rd(32'h00, d);
        chk("ack_pend", d, 32'h0);

        // Rising edge lands on the same edge as a CLEAR commit
        IRQ_In[1] = 1'b1;
        tick(1);
        bus_addr(1'b1, 32'h0C, 3'b010);
        tick(1);
        HWDATA = 32'h2;
        bus_idle();
        tick(1);
        rd(32'h00, d);
        chk("set_wins", d, 32'h2);
        IRQ_In[1] = 1'b0;
        wr(32'h0C, 32'h2);
        rd(32'h00, d);
        chk("clear_pend", d, 32'h0);
        rd(32'h0C, d);
        chk("clear_reads0", d, 32'h0);

        // Equal priority tie, then mask the lower index
        wr(32'h08, 32'h00);
        wr(32'h04, 32'h48);
        wr(32'h10, 32'h0400_4753);
        IRQ_In = 8'h48;
        tick(4);
        chk("tie_vec", 32'(SI_EICVector), 32'd3);
        chk("tie_int", 32'(SI_Int), 32'd4);
        wr(32'h04, 32'h40);
        chk("mask_lag", 32'(SI_EICVector), 32'd3);
        tick(1);
        chk("mask_vec", 32'(SI_EICVector), 32'd6);
        chk("mask_int", 32'(SI_Int), 32'd4);
        IRQ_In = '0;
        tick(4);

        // Shadow register set for source 2
        wr(32'h24, 32'h0000_0300);
        wr(32'h04, 32'h04);
        IRQ_In = 8'h04;
        tick(4);
        chk("srs_int", 32'(SI_Int), 32'd7);
        rd(32'h24, d);
`ifdef MFP_EIC_SHADOW_EN
        chk("srs_eiss", 32'(SI_EISS), 32'd3);
        chk("srs_rd", d, 32'h300);
`else
        chk("srs_eiss", 32'(SI_EISS), 32'd0);
        chk("srs_rd", d, 32'h0);
`endif

        // Reset in mid-operation
        SI_Reset = 1'b1;
        tick(1);
        SI_Reset = 1'b0;
        chk("rst_int", 32'(SI_Int), 32'd0);
        chk("rst_vec", 32'(SI_EICVector), 32'd0);
        chk("rst_present", 32'(SI_EICPresent), 32'd1);
        rd(32'h04, d);
        chk("rst_mask", d, 32'h0);
        tick(4);
        chk("rst_quiet", 32'(SI_Int), 32'd0);
        IRQ_In = '0;

        // Width limits, unmapped offsets and non-word writes
        wr(32'h04, 32'hFFFF_FFFF);
        rd(32'h04, d);
        chk("mask_width", d, 32'hFF);
        wr(32'h14, 32'hFFFF_FFFF);
        rd(32'h14, d);
        chk("prio_hi_word", d, 32'h0);
        wr(32'h34, 32'hFFFF_FFFF);
        rd(32'h34, d);
        chk("unmapped", d, 32'h0);
        wr(32'h04, 32'h0, 3'b000);
        rd(32'h04, d);
        chk("byte_ignored", d, 32'hFF);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
